// File: rtl/fft_twiddle_fetch_if.sv
// Twiddle stream handshake between the fetch unit and the butterfly.
// The master drives the FIFO head; the slave returns ready.
interface fft_twiddle_fetch_if #(
   parameter int DATA_W = 16
);
   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] data;
   logic [3:0]        index;
   logic              last;

   modport master (
      output valid, data, index, last,
      input  ready
   );

   modport slave (
      input  valid, data, index, last,
      output ready
   );
endinterface

// File: rtl/fft_twiddle_fetch.sv
// Twiddle ROM sequencer: issues one FFT stage's ROM addresses and streams
// the returned words through a credit-limited FIFO to the butterfly.
module fft_twiddle_fetch #(
   parameter int ADDR_W     = 5,
   parameter int DATA_W     = 16,
   parameter int MAX_STAGE  = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic [2:0]            stage_i,
   output logic                  busy_o,
   output logic                  err_o,
   output logic [ADDR_W-1:0]     rom_addr_o,
   input  logic [DATA_W-1:0]     rom_data_i,
   fft_twiddle_fetch_if.master   tw
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [3:0]        idx;
      logic              last;
   } ent_t;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W-1:0] count_q, count_d;
   logic [ADDR_W-1:0] issued_q, issued_d;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic              err_q, err_d;

   // av: address on the ROM bus now; dv: ROM word valid now
   logic              av_q, av_d;
   logic [3:0]        a_idx_q, a_idx_d;
   logic              a_last_q, a_last_d;
   logic              dv_q;
   logic [3:0]        d_idx_q;
   logic              d_last_q;

   ent_t              mem_q [FIFO_DEPTH];
   logic [PW-1:0]     wptr_q, rptr_q;
   logic [CW-1:0]     fcnt_q, fcnt_d;

   logic              push, pop, credit_ok;
   logic [CW:0]       used;
   logic [ADDR_W-1:0] pow;
   ent_t              head;

   assign push = dv_q;
   assign pop  = tw.valid & tw.ready;

   assign used = {1'b0, fcnt_q} + (CW+1)'(av_q) + (CW+1)'(dv_q);
   assign credit_ok = used < (CW+1)'(FIFO_DEPTH);

   assign pow = ADDR_W'(1) << stage_i;

   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      count_d    = count_q;
      issued_d   = issued_q;
      rom_addr_d = rom_addr_q;
      err_d      = 1'b0;
      av_d       = 1'b0;
      a_idx_d    = a_idx_q;
      a_last_d   = a_last_q;
      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               if (stage_i > 3'(MAX_STAGE)) begin
                  err_d = 1'b1;
               end else begin
                  base_d     = pow - ADDR_W'(1);
                  count_d    = pow;
                  rom_addr_d = pow - ADDR_W'(1);
                  issued_d   = ADDR_W'(1);
                  av_d       = 1'b1;
                  a_idx_d    = 4'd0;
                  a_last_d   = (stage_i == 3'd0);
                  state_d    = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            if (issued_q >= count_q) begin
               state_d = S_DRAIN;
            end else if (credit_ok) begin
               rom_addr_d = base_q + issued_q;
               issued_d   = issued_q + ADDR_W'(1);
               av_d       = 1'b1;
               a_idx_d    = issued_q[3:0];
               a_last_d   = (issued_q == count_q - ADDR_W'(1));
               if (issued_q + ADDR_W'(1) == count_q) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (fcnt_q == '0 && !av_q && !dv_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      fcnt_d = fcnt_q;
      unique case ({push, pop})
         2'b10:   fcnt_d = fcnt_q + CW'(1);
         2'b01:   fcnt_d = fcnt_q - CW'(1);
         default: fcnt_d = fcnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         base_q     <= '0;
         count_q    <= '0;
         issued_q   <= '0;
         rom_addr_q <= '0;
         err_q      <= 1'b0;
         av_q       <= 1'b0;
         a_idx_q    <= '0;
         a_last_q   <= 1'b0;
         dv_q       <= 1'b0;
         d_idx_q    <= '0;
         d_last_q   <= 1'b0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         fcnt_q     <= '0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         count_q    <= count_d;
         issued_q   <= issued_d;
         rom_addr_q <= rom_addr_d;
         err_q      <= err_d;
         av_q       <= av_d;
         a_idx_q    <= a_idx_d;
         a_last_q   <= a_last_d;
         dv_q       <= av_q;
         d_idx_q    <= a_idx_q;
         d_last_q   <= a_last_q;
         fcnt_q     <= fcnt_d;
         if (push) wptr_q <= wptr_q + PW'(1);
         if (pop)  rptr_q <= rptr_q + PW'(1);
      end
   end

   // Storage needs no reset; the head is masked while the FIFO is empty
   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= '{data: rom_data_i, idx: d_idx_q, last: d_last_q};
   end

   assign head = mem_q[rptr_q];

   assign tw.valid   = (fcnt_q != '0);
   assign tw.data    = tw.valid ? head.data : '0;
   assign tw.index   = tw.valid ? head.idx  : '0;
   assign tw.last    = tw.valid & head.last;

   assign busy_o     = (state_q != S_IDLE);
   assign err_o      = err_q;
   assign rom_addr_o = rom_addr_q;

endmodule
